// File: rtl/dds_param_set.sv
// DDS parameter-entry controller.
// Three raw push-buttons (active-low) are synchronised and debounced, then
// turned into press events. The up/down keys also auto-repeat while held.
// Press events cycle the waveform mode and step the frequency tuning word
// with saturation. All outputs are registered.

// Per-key conditioning: 2-FF synchroniser, debouncer, post-reset arming,
// press strobe and optional hold-to-repeat strobe.
module dds_key_cond #(
  parameter int DEB_CYC = 1_000_000,
  parameter int RPT_DLY = 25_000_000,
  parameter int RPT_PER = 5_000_000,
  parameter bit RPT_EN  = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_i,
  output logic press_o,
  output logic rpt_o
);

  localparam int DEB_W    = $clog2(DEB_CYC + 1);
  localparam int HOLD_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [HOLD_W-1:0] DLY_CNT  = HOLD_W'(RPT_DLY);
  localparam logic [HOLD_W-1:0] PER_CNT  = HOLD_W'(RPT_PER);

  logic              sync1_q, sync2_q;
  logic              deb_q, deb_prev_q;
  logic [DEB_W-1:0]  deb_cnt_q;
  logic [DEB_W-1:0]  rel_cnt_q;
  logic              armed_q;
  logic              press_q;
  logic              run_q, phase_q, rpt_q;
  logic [HOLD_W-1:0] hold_q;
  logic              press_d;

  // Two-stage synchroniser; idle (released) level is 1.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its sources, regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  // Debouncer: follow the synchronised level after DEB_CYC consecutive
  // differing cycles; any return to the current state restarts the count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
      deb_cnt_q  <= '0;
    end else begin
      deb_prev_q <= deb_q;
      if (sync2_q != deb_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          deb_q     <= sync2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  // Arming: after reset the key must be seen released for DEB_CYC cycles
  // before presses count, so a key held through reset produces no event.
  // The synchroniser resets to 1, so DEB_CYC must exceed its 2-cycle fill.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      armed_q   <= 1'b0;
      rel_cnt_q <= '0;
    end else if (!armed_q) begin
      if (!sync2_q) begin
        rel_cnt_q <= '0;
      end else if (rel_cnt_q == DEB_LAST) begin
        armed_q <= 1'b1;
      end else begin
        rel_cnt_q <= rel_cnt_q + 1'b1;
      end
    end
  end

  assign press_d = deb_prev_q & ~deb_q & armed_q;

  // Press event register: one-cycle strobe on a debounced 1->0 transition.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      press_q <= 1'b0;
    end else begin
      press_q <= press_d;
    end
  end

  // Hold counter: first repeat RPT_DLY cycles after the press strobe, then
  // every RPT_PER cycles; cleared as soon as the debounced key is released.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_q   <= 1'b0;
      phase_q <= 1'b0;
      hold_q  <= '0;
      rpt_q   <= 1'b0;
    end else if (deb_q || !RPT_EN) begin
      run_q   <= 1'b0;
      phase_q <= 1'b0;
      hold_q  <= '0;
      rpt_q   <= 1'b0;
    end else if (press_d) begin
      run_q   <= 1'b1;
      phase_q <= 1'b0;
      hold_q  <= HOLD_W'(1);
      rpt_q   <= 1'b0;
    end else if (run_q) begin
      if ((!phase_q && hold_q == DLY_CNT) || (phase_q && hold_q == PER_CNT)) begin
        rpt_q   <= 1'b1;
        phase_q <= 1'b1;
        hold_q  <= HOLD_W'(1);
      end else begin
        rpt_q  <= 1'b0;
        hold_q <= hold_q + 1'b1;
      end
    end else begin
      rpt_q <= 1'b0;
    end
  end

  assign press_o = press_q;
  assign rpt_o   = rpt_q;

endmodule

// Top: three conditioned keys drive the registered wave/frequency outputs.
module dds_param_set #(
  parameter int DEB_CYC = 1_000_000,
  parameter int RPT_DLY = 25_000_000,
  parameter int RPT_PER = 5_000_000,
  parameter int N_WAVE  = 4,
  parameter int WAVE_W  = 2,
  parameter int FW_W    = 32,
  parameter logic [FW_W-1:0] FW_STEP = FW_W'(86),
  parameter logic [FW_W-1:0] FW_MIN  = FW_W'(86),
  parameter logic [FW_W-1:0] FW_MAX  = FW_W'(64'd2147483648),
  parameter logic [FW_W-1:0] FW_INIT = FW_W'(859)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              key_wave_in,
  input  logic              key_up_in,
  input  logic              key_dn_in,
  output logic [WAVE_W-1:0] wave_c,
  output logic [FW_W-1:0]   freq_word,
  output logic              cfg_upd
);

  localparam logic [WAVE_W-1:0] WAVE_LAST = WAVE_W'(N_WAVE - 1);
  localparam logic [FW_W:0]     STEP_X    = {1'b0, FW_STEP};
  localparam logic [FW_W:0]     MIN_X     = {1'b0, FW_MIN};
  localparam logic [FW_W:0]     MAX_X     = {1'b0, FW_MAX};
  // Below this value a down step would cross FW_MIN (or underflow).
  localparam logic [FW_W:0]     LOW_THR   = MIN_X + STEP_X;

  logic wave_press, wave_rpt, up_press, up_rpt, dn_press, dn_rpt;
  logic wave_ev, up_ev, dn_ev;

  logic [WAVE_W-1:0] wave_q, wave_d;
  logic [FW_W-1:0]   fw_q, fw_d;
  logic              upd_q, upd_d;
  logic [FW_W:0]     fw_x, sum_x;
  logic [FW_W-1:0]   up_val, dn_val;

  dds_key_cond #(
    .DEB_CYC (DEB_CYC),
    .RPT_DLY (RPT_DLY),
    .RPT_PER (RPT_PER),
    .RPT_EN  (1'b0)
  ) u_key_wave (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_i     (key_wave_in),
    .press_o   (wave_press),
    .rpt_o     (wave_rpt)
  );

  dds_key_cond #(
    .DEB_CYC (DEB_CYC),
    .RPT_DLY (RPT_DLY),
    .RPT_PER (RPT_PER),
    .RPT_EN  (1'b1)
  ) u_key_up (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_i     (key_up_in),
    .press_o   (up_press),
    .rpt_o     (up_rpt)
  );

  dds_key_cond #(
    .DEB_CYC (DEB_CYC),
    .RPT_DLY (RPT_DLY),
    .RPT_PER (RPT_PER),
    .RPT_EN  (1'b1)
  ) u_key_dn (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_i     (key_dn_in),
    .press_o   (dn_press),
    .rpt_o     (dn_rpt)
  );

  // Next-state logic: wave wrap at N_WAVE, saturating steps in FW_W+1 bits,
  // opposing steps cancel, update pulse only on an actual value change.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wave_ev = wave_press | wave_rpt;
    up_ev   = up_press | up_rpt;
    dn_ev   = dn_press | dn_rpt;

    fw_x   = {1'b0, fw_q};
    sum_x  = fw_x + STEP_X;
    up_val = (sum_x > MAX_X) ? FW_MAX : sum_x[FW_W-1:0];
    dn_val = (fw_x < LOW_THR) ? FW_MIN : (fw_q - FW_STEP);

    wave_d = wave_q;
    if (wave_ev) begin
      wave_d = (wave_q == WAVE_LAST) ? '0 : wave_q + 1'b1;
    end

    fw_d = fw_q;
    if (up_ev && !dn_ev) begin
      fw_d = up_val;
    end else if (dn_ev && !up_ev) begin
      fw_d = dn_val;
    end

    upd_d = (wave_d != wave_q) || (fw_d != fw_q);
  end

  // Output registers; cfg_upd rises on the same edge as the new values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wave_q <= '0;
      fw_q   <= FW_INIT;
      upd_q  <= 1'b0;
    end else begin
      wave_q <= wave_d;
      fw_q   <= fw_d;
      upd_q  <= upd_d;
    end
  end

  assign wave_c    = wave_q;
  assign freq_word = fw_q;
  assign cfg_upd   = upd_q;

endmodule

// File: tb/tb_dds_param_set.sv
// Directed bench for dds_param_set with short debounce/repeat timing.
// Table vectors press keys and check final outputs and pulse counts;
// hand-written sequences cover latency, auto-repeat timing and reset.
module tb_dds_param_set;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        key_wave_in, key_up_in, key_dn_in;
  logic [1:0]  wave_c;
  logic [31:0] freq_word;
  logic        cfg_upd;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int upd_cnt  = 0;
  int bad_wave = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  w;
    logic [31:0] fw;
  } ev_t;
  ev_t log_q[$];

  typedef struct {
    string       name;
    logic        w, u, d;
    int          hold;
    logic [1:0]  exp_wave;
    logic [31:0] exp_fw;
    int          exp_pulses;
  } vec_t;

  dds_param_set #(
    .DEB_CYC (4),
    .RPT_DLY (20),
    .RPT_PER (5),
    .N_WAVE  (3),
    .WAVE_W  (2),
    .FW_W    (32),
    .FW_STEP (32'd100),
    .FW_MIN  (32'd100),
    .FW_MAX  (32'd1000),
    .FW_INIT (32'd500)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_wave_in (key_wave_in),
    .key_up_in   (key_up_in),
    .key_dn_in   (key_dn_in),
    .wave_c      (wave_c),
    .freq_word   (freq_word),
    .cfg_upd     (cfg_upd)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Monitor: sample 1 ns after each rising edge, log every update pulse.
  always @(posedge sys_clk) begin
    #1;
    cyc++;
    if (cfg_upd === 1'b1) begin
      upd_cnt++;
      log_q.push_back('{cyc: cyc, w: wave_c, fw: freq_word});
    end
    if (wave_c > 2'd2) bad_wave++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic apply_vec(input vec_t v);
    int base;
    base = upd_cnt;
    key_wave_in = ~v.w;
    key_up_in   = ~v.u;
    key_dn_in   = ~v.d;
    wait_cyc(v.hold);
    key_wave_in = 1'b1;
    key_up_in   = 1'b1;
    key_dn_in   = 1'b1;
    wait_cyc(20);
    check({v.name, " wave"}, 64'(wave_c), 64'(v.exp_wave));
    check({v.name, " freq"}, 64'(freq_word), 64'(v.exp_fw));
    check({v.name, " pulses"}, 64'(upd_cnt - base), 64'(v.exp_pulses));
  endtask

  vec_t vecs[20];
  ev_t  exp_rpt[5];

  initial begin
    // name, wave, up, dn, hold, exp wave, exp freq, exp pulses
    vecs[0]  = '{"wave1",   1, 0, 0, 10, 2'd1, 32'd500,  1};
    vecs[1]  = '{"wave2",   1, 0, 0, 10, 2'd2, 32'd500,  1};
    vecs[2]  = '{"wave0",   1, 0, 0, 10, 2'd0, 32'd500,  1};
    vecs[3]  = '{"glitch",  0, 1, 0,  3, 2'd0, 32'd500,  0};
    vecs[4]  = '{"dn900",   0, 0, 1, 10, 2'd0, 32'd900,  1};
    vecs[5]  = '{"updn",    0, 1, 1, 10, 2'd0, 32'd900,  0};
    vecs[6]  = '{"dn800",   0, 0, 1, 10, 2'd0, 32'd800,  1};
    vecs[7]  = '{"dn700",   0, 0, 1, 10, 2'd0, 32'd700,  1};
    vecs[8]  = '{"dn600",   0, 0, 1, 10, 2'd0, 32'd600,  1};
    vecs[9]  = '{"dn500",   0, 0, 1, 10, 2'd0, 32'd500,  1};
    vecs[10] = '{"wavedn",  1, 0, 1, 10, 2'd1, 32'd400,  1};
    vecs[11] = '{"rdn400",  0, 0, 1, 10, 2'd0, 32'd400,  1};
    vecs[12] = '{"rdn300",  0, 0, 1, 10, 2'd0, 32'd300,  1};
    vecs[13] = '{"rdn200",  0, 0, 1, 10, 2'd0, 32'd200,  1};
    vecs[14] = '{"rdn100",  0, 0, 1, 10, 2'd0, 32'd100,  1};
    vecs[15] = '{"satlow",  0, 0, 1, 10, 2'd0, 32'd100,  0};
    vecs[16] = '{"up200",   0, 1, 0, 10, 2'd0, 32'd200,  1};
    vecs[17] = '{"wave1b",  1, 0, 0, 10, 2'd1, 32'd200,  1};
    vecs[18] = '{"wave2b",  1, 0, 0, 10, 2'd2, 32'd200,  1};
    vecs[19] = '{"wave0b",  1, 0, 0, 10, 2'd0, 32'd200,  1};

    // Key-up held from raw edge: press at +8, repeats at +28, +33, +38, +43.
    exp_rpt[0] = '{cyc: 8,  w: 2'd0, fw: 32'd600};
    exp_rpt[1] = '{cyc: 28, w: 2'd0, fw: 32'd700};
    exp_rpt[2] = '{cyc: 33, w: 2'd0, fw: 32'd800};
    exp_rpt[3] = '{cyc: 38, w: 2'd0, fw: 32'd900};
    exp_rpt[4] = '{cyc: 43, w: 2'd0, fw: 32'd1000};

    sys_rst_n   = 1'b0;
    key_wave_in = 1'b1;
    key_up_in   = 1'b1;
    key_dn_in   = 1'b1;
    wait_cyc(3);
    check("rst wave", 64'(wave_c), 64'd0);
    check("rst freq", 64'(freq_word), 64'd500);
    check("rst upd", 64'(cfg_upd), 64'd0);
    sys_rst_n = 1'b1;
    wait_cyc(50);
    check("idle wave", 64'(wave_c), 64'd0);
    check("idle freq", 64'(freq_word), 64'd500);
    check("idle pulses", 64'(upd_cnt), 64'd0);

    for (int i = 0; i <= 3; i++) apply_vec(vecs[i]);

    // Clean key-up press held 60 cycles: latency, repeat timing, saturation.
    begin
      int c0;
      log_q.delete();
      c0 = cyc;
      key_up_in = 1'b0;
      wait_cyc(60);
      key_up_in = 1'b1;
      wait_cyc(20);
      check("rpt count", 64'(log_q.size()), 64'd5);
      for (int i = 0; i < 5; i++) begin
        if (i < log_q.size()) begin
          check($sformatf("rpt%0d cycle", i), 64'(log_q[i].cyc - c0), 64'(exp_rpt[i].cyc));
          check($sformatf("rpt%0d freq", i), 64'(log_q[i].fw), 64'(exp_rpt[i].fw));
        end
      end
      check("sat freq", 64'(freq_word), 64'd1000);
    end

    for (int i = 4; i <= 10; i++) apply_vec(vecs[i]);

    // Reset while key_dn auto-repeats at 200; key held through reset release.
    begin
      int base;
      key_dn_in = 1'b0;
      wait_cyc(30);
      check("hold dn freq", 64'(freq_word), 64'd200);
      check("hold dn wave", 64'(wave_c), 64'd1);
      sys_rst_n = 1'b0;
      wait_cyc(1);
      check("mid rst wave", 64'(wave_c), 64'd0);
      check("mid rst freq", 64'(freq_word), 64'd500);
      check("mid rst upd", 64'(cfg_upd), 64'd0);
      wait_cyc(2);
      sys_rst_n = 1'b1;
      base = upd_cnt;
      wait_cyc(60);
      check("held freq", 64'(freq_word), 64'd500);
      check("held pulses", 64'(upd_cnt - base), 64'd0);
      key_dn_in = 1'b1;
      wait_cyc(20);
      check("released pulses", 64'(upd_cnt - base), 64'd0);
    end

    for (int i = 11; i <= 19; i++) apply_vec(vecs[i]);

    check("wave range", 64'(bad_wave), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
